// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-pipe result FIFOs feed NUM_WB_PORTS PRF write ports
// through a round-robin selector; the wakeup broadcast mirrors the PRF writes.
module wb_arbiter #(
  parameter int NUM_EX_PIPES = 4,
  parameter int NUM_WB_PORTS = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int NUM_PREGS    = 128,
  parameter int PREG_W       = $clog2(NUM_PREGS),
  parameter int DATA_W       = 32
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              flush,
  input  logic [NUM_EX_PIPES-1:0]                           ex_valid,
  output logic [NUM_EX_PIPES-1:0]                           ex_ready,
  input  logic [NUM_EX_PIPES*PREG_W-1:0]                    ex_dst_index,
  input  logic [NUM_EX_PIPES*DATA_W-1:0]                    ex_dst_val,
  output logic [NUM_WB_PORTS-1:0]                           prf_wr_valid,
  output logic [NUM_WB_PORTS*PREG_W-1:0]                    prf_wr_index,
  output logic [NUM_WB_PORTS*DATA_W-1:0]                    prf_wr_val,
  output logic [NUM_WB_PORTS-1:0]                           wakeup_valid,
  output logic [NUM_WB_PORTS*PREG_W-1:0]                    wakeup_index,
  output logic [NUM_EX_PIPES*($clog2(FIFO_DEPTH)+1)-1:0]    fifo_occ
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int PIPE_W = (NUM_EX_PIPES > 1) ? $clog2(NUM_EX_PIPES) : 1;

  typedef struct packed {
    logic [PREG_W-1:0] idx;
    logic [DATA_W-1:0] val;
  } entry_t;

  entry_t                  mem    [NUM_EX_PIPES][FIFO_DEPTH];
  entry_t                  head   [NUM_EX_PIPES];
  logic [PTR_W-1:0]        rd_ptr [NUM_EX_PIPES];
  logic [PTR_W-1:0]        wr_ptr [NUM_EX_PIPES];
  logic [OCC_W-1:0]        occ    [NUM_EX_PIPES];
  logic [PIPE_W-1:0]       rr_ptr;
  logic [PIPE_W-1:0]       rr_next;
  logic [NUM_EX_PIPES-1:0] push;
  logic [NUM_EX_PIPES-1:0] grant;
  logic [NUM_WB_PORTS-1:0] port_vld;
  logic [PIPE_W-1:0]       port_sel [NUM_WB_PORTS];

  // Ready comes from occupancy only (plus reset), never from this cycle's grants.
  always_comb begin
    for (int i = 0; i < NUM_EX_PIPES; i++) begin
      ex_ready[i]                = rst_n && (occ[i] < OCC_W'(FIFO_DEPTH));
      push[i]                    = ex_valid[i] && ex_ready[i] && !flush;
      head[i]                    = mem[i][rd_ptr[i]];
      fifo_occ[i*OCC_W +: OCC_W] = occ[i];
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    int p;
    int cnt;
    p        = 0;
    cnt      = 0;
    grant    = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    for (int w = 0; w < NUM_WB_PORTS; w++) port_sel[w] = '0;
    for (int k = 0; k < NUM_EX_PIPES; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_EX_PIPES) p = p - NUM_EX_PIPES;
      if ((occ[p] != '0) && (cnt < NUM_WB_PORTS)) begin
        grant[p]      = 1'b1;
        port_vld[cnt] = 1'b1;
        port_sel[cnt] = PIPE_W'(p);
        cnt           = cnt + 1;
        rr_next       = (p == NUM_EX_PIPES - 1) ? '0 : PIPE_W'(p + 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_EX_PIPES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else if (flush) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_EX_PIPES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      rr_ptr <= rr_next;
      for (int i = 0; i < NUM_EX_PIPES; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        occ[i] <= occ[i] + OCC_W'(push[i]) - OCC_W'(grant[i]);
      end
    end
  end

  // NOTE: storage is not reset; pointers and occupancy alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EX_PIPES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{idx: ex_dst_index[i*PREG_W +: PREG_W],
                               val: ex_dst_val[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Ungranted ports drop valid but keep their last index/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prf_wr_valid <= '0;
      prf_wr_index <= '0;
      prf_wr_val   <= '0;
    end else if (flush) begin
      prf_wr_valid <= '0;
    end else begin
      prf_wr_valid <= port_vld;
      for (int w = 0; w < NUM_WB_PORTS; w++) begin
        if (port_vld[w]) begin
          prf_wr_index[w*PREG_W +: PREG_W] <= head[port_sel[w]].idx;
          prf_wr_val[w*DATA_W +: DATA_W]   <= head[port_sel[w]].val;
        end
      end
    end
  end

  assign wakeup_valid = prf_wr_valid;
  assign wakeup_index = prf_wr_index;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-level reference model feeds an expected-output
// scoreboard that a negedge monitor drains and compares every cycle.
module tb_wb_arbiter;

  localparam int NP    = 4;
  localparam int NW    = 2;
  localparam int DEPTH = 4;
  localparam int NPREG = 128;
  localparam int PW    = 7;
  localparam int DW    = 32;
  localparam int OW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [NP-1:0]    ex_valid = '0;
  logic [NP-1:0]    ex_ready;
  logic [NP*PW-1:0] ex_dst_index = '0;
  logic [NP*DW-1:0] ex_dst_val = '0;
  logic [NW-1:0]    prf_wr_valid;
  logic [NW*PW-1:0] prf_wr_index;
  logic [NW*DW-1:0] prf_wr_val;
  logic [NW-1:0]    wakeup_valid;
  logic [NW*PW-1:0] wakeup_index;
  logic [NP*OW-1:0] fifo_occ;

  wb_arbiter #(
    .NUM_EX_PIPES(NP), .NUM_WB_PORTS(NW), .FIFO_DEPTH(DEPTH),
    .NUM_PREGS(NPREG), .PREG_W(PW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_dst_index(ex_dst_index), .ex_dst_val(ex_dst_val),
    .prf_wr_valid(prf_wr_valid), .prf_wr_index(prf_wr_index), .prf_wr_val(prf_wr_val),
    .wakeup_valid(wakeup_valid), .wakeup_index(wakeup_index),
    .fifo_occ(fifo_occ)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue of results per pipe, a round-robin start pipe,
  // and the expected registered port contents for each clock edge.
  typedef struct packed {
    logic [PW-1:0] idx;
    logic [DW-1:0] val;
  } res_t;

  typedef struct packed {
    logic [NW-1:0]    vld;
    logic [NW*PW-1:0] idx;
    logic [NW*DW-1:0] val;
  } out_t;

  res_t          mq [NP][$];
  out_t          expq [$];
  out_t          last_out = '0;
  int            rr = 0;
  logic [NP-1:0] mdl_acc = '0;
  int            issued [NP];
  int            wr_cnt [16];
  bit            saw_full = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [NP-1:0] acc;
    int   n;
    int   p;
    int   last;
    res_t r;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      expq.delete();
      last_out = '0;
      rr       = 0;
      mdl_acc  = '0;
    end else begin
      acc = '0;
      for (int i = 0; i < NP; i++)
        if (ex_valid[i] && (mq[i].size() < DEPTH)) acc[i] = 1'b1;
      mdl_acc      = acc;
      last_out.vld = '0;
      if (flush) begin
        for (int i = 0; i < NP; i++) mq[i].delete();
        rr = 0;
      end else begin
        n    = 0;
        last = 0;
        for (int k = 0; k < NP; k++) begin
          p = (rr + k) % NP;
          if ((mq[p].size() > 0) && (n < NW)) begin
            r = mq[p].pop_front();
            last_out.vld[n]          = 1'b1;
            last_out.idx[n*PW +: PW] = r.idx;
            last_out.val[n*DW +: DW] = r.val;
            n++;
            last = p;
          end
        end
        if (n > 0) rr = (last + 1) % NP;
        for (int i = 0; i < NP; i++) begin
          if (acc[i]) begin
            r.idx = ex_dst_index[i*PW +: PW];
            r.val = ex_dst_val[i*DW +: DW];
            mq[i].push_back(r);
          end
        end
      end
      expq.push_back(last_out);
    end
  end

  always @(negedge clk) begin : monitor
    out_t          e;
    logic [NP-1:0] er;
    logic [NP*OW-1:0] eo;
    e = '0;
    if (expq.size() > 0) e = expq.pop_front();
    for (int i = 0; i < NP; i++) begin
      er[i]            = rst_n && (mq[i].size() < DEPTH);
      eo[i*OW +: OW]   = OW'(mq[i].size());
    end
    check("wr_valid", 128'(prf_wr_valid), 128'(e.vld));
    check("wr_index", 128'(prf_wr_index), 128'(e.idx));
    check("wr_val",   128'(prf_wr_val),   128'(e.val));
    check("wk_valid", 128'(wakeup_valid), 128'(e.vld));
    check("wk_index", 128'(wakeup_index), 128'(e.idx));
    check("ex_ready", 128'(ex_ready),     128'(er));
    check("fifo_occ", 128'(fifo_occ),     128'(eo));
    for (int w = 0; w < NW; w++)
      if (prf_wr_valid[w]) wr_cnt[int'(prf_wr_val[w*DW+28 +: 4])]++;
    if ((fifo_occ[OW +: OW] == OW'(DEPTH)) && !ex_ready[1]) saw_full = 1'b1;
  end

  task automatic set_pipe(input int i, input logic [PW-1:0] idx, input logic [DW-1:0] val);
    ex_valid[i]              = 1'b1;
    ex_dst_index[i*PW +: PW] = idx;
    ex_dst_val[i*DW +: DW]   = val;
  endtask

  // A producer holds its result until the handshake; new results carry the
  // pipe number in the top nibble of the data.
  task automatic drive(input logic [NP-1:0] want);
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      if (ex_valid[i] && !mdl_acc[i]) continue;
      ex_valid[i] = want[i];
      if (want[i]) begin
        ex_dst_index[i*PW +: PW] = PW'($urandom);
        ex_dst_val[i*DW +: DW]   = {4'(i), 28'($urandom)};
        issued[i]++;
      end
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < NP; i++) issued[i] = 0;
    for (int i = 0; i < 16; i++) wr_cnt[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_ready", 128'(ex_ready), 128'(0));
    check("rst_valid", 128'(prf_wr_valid), 128'(0));
    #2 rst_n = 1'b1;

    // single result on pipe 2, two cycles of latency
    @(negedge clk);
    set_pipe(2, 7'd7, 32'hDEADBEEF);
    drive('0);
    @(negedge clk);
    check("single_valid", 128'(prf_wr_valid), 128'(2'b01));
    check("single_index", 128'(prf_wr_index[PW-1:0]), 128'(7));
    check("single_val",   128'(prf_wr_val[DW-1:0]), 128'(32'hDEADBEEF));
    check("single_wake",  128'(wakeup_index[PW-1:0]), 128'(7));

    // contention: flush first so the round-robin start is pipe 0
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < NP; i++) set_pipe(i, PW'(i + 1), {4'(i), 28'(i * 16)});
    drive('0);
    @(negedge clk);
    check("cont1_valid", 128'(prf_wr_valid), 128'(2'b11));
    check("cont1_index", 128'(prf_wr_index), 128'({7'd2, 7'd1}));
    @(negedge clk);
    check("cont2_valid", 128'(prf_wr_valid), 128'(2'b11));
    check("cont2_index", 128'(prf_wr_index), 128'({7'd4, 7'd3}));

    // fairness between pipes 0 and 3
    repeat (3) drive('0);
    for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
    repeat (20) drive(4'b1001);
    check("fair_p0", 128'(wr_cnt[0] >= 15), 128'(1));
    check("fair_p3", 128'(wr_cnt[3] >= 15), 128'(1));
    repeat (4) drive('0);

    // backpressure on pipe 1 with the ports saturated by the others
    base     = issued[1];
    saw_full = 1'b0;
    for (int c = 0; c < 80; c++) drive(4'b1101 | (((issued[1] - base) < 12) ? 4'b0010 : 4'b0000));
    check("bp_full_seen", 128'(saw_full), 128'(1));
    repeat (25) drive('0);

    // flush with pipe 0 holding buffered results and presenting one more
    repeat (8) drive(4'b1111);
    check("flush_prefill", 128'(fifo_occ[OW-1:0] >= 3'd3), 128'(1));
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    ex_valid = '0;
    check("flush_valid", 128'(prf_wr_valid), 128'(0));
    check("flush_occ",   128'(fifo_occ), 128'(0));
    check("flush_ready", 128'(ex_ready), 128'({NP{1'b1}}));
    @(negedge clk);
    check("flush_drop", 128'(prf_wr_valid), 128'(0));

    // asynchronous reset between edges during traffic
    repeat (6) drive(4'b1111);
    #2 rst_n = 1'b0;
    ex_valid = '0;
    #1;
    check("arst_valid", 128'(prf_wr_valid), 128'(0));
    check("arst_ready", 128'(ex_ready), 128'(0));
    check("arst_occ",   128'(fifo_occ), 128'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    set_pipe(1, 7'd9, 32'h12345678);
    drive('0);
    @(negedge clk);
    check("post_rst_valid", 128'(prf_wr_valid), 128'(2'b01));
    check("post_rst_index", 128'(prf_wr_index[PW-1:0]), 128'(9));
    check("post_rst_val",   128'(prf_wr_val[DW-1:0]), 128'(32'h12345678));

    // random traffic with occasional flushes
    for (int c = 0; c < 300; c++) begin
      drive(NP'($urandom));
      flush = ($urandom_range(39) == 0);
    end
    flush = 1'b0;
    repeat (20) drive('0);
    check("drained_occ", 128'(fifo_occ), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
